// File: rtl/btn_event_arbiter_pkg.sv
// Shared definitions for the button event arbiter.
//   arb_state_e  : arbiter FSM states (IDLE, OFFER)
//   EVT_ID_W     : width of the event button index
//   LOCKOUT_DEF  : default per-button lockout after an accepted press (clk cycles)
//   LONG_CYC_DEF : default continuous-high time that defines a long press (clk cycles)
package btn_event_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_e;

    localparam int EVT_ID_W     = 3;
    localparam int LOCKOUT_DEF  = 2000;
    localparam int LONG_CYC_DEF = 50_000_000;

endpackage

// File: rtl/btn_event_arbiter_btn_channel.sv
// Per-button front end: 2-FF synchronizer, rising-edge detect, press lockout
// and (with BTN_LONG_PRESS_EN defined) a saturating hold counter.
// Ports:
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   bt_i    : raw button level, asynchronous to clk_i
//   press_o : one-cycle pulse, a press has been accepted this cycle
//   long_o  : one-cycle pulse, the button has been held LONG_CYC cycles
//             (present only with BTN_LONG_PRESS_EN)
module btn_channel
    import btn_event_arbiter_pkg::*;
#(
    parameter int LOCKOUT = LOCKOUT_DEF
`ifdef BTN_LONG_PRESS_EN
    , parameter int LONG_CYC = LONG_CYC_DEF
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bt_i,
    output logic press_o
`ifdef BTN_LONG_PRESS_EN
    , output logic long_o
`endif
);

    localparam int LW = $clog2(LOCKOUT + 1);

    logic          s1_q, s2_q, s3_q;
    logic [LW-1:0] lock_q;
    logic          rise;

    assign rise    = s2_q & ~s3_q;
    // Rises that land inside the lockout window are simply dropped.
    assign press_o = rise && (lock_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            lock_q <= '0;
        end else begin
            s1_q <= bt_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (press_o) begin
                lock_q <= LW'(LOCKOUT);
            end else if (lock_q != '0) begin
                lock_q <= lock_q - LW'(1);
            end
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYC + 1);

    logic [HW-1:0] hold_q;

    // Fires exactly once per hold: the counter saturates at LONG_CYC and
    // only restarts after the synchronized level drops.
    assign long_o = s2_q && (hold_q == HW'(LONG_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else if (!s2_q) begin
            hold_q <= '0;
        end else if (hold_q != HW'(LONG_CYC)) begin
            hold_q <= hold_q + HW'(1);
        end
    end
`endif

endmodule

// File: rtl/btn_event_arbiter.sv
// Button event arbiter: N_BTN debounced/locked-out button channels feed
// per-button pending flags; a round-robin arbiter offers one event at a
// time over a valid/ready handshake.
// Optional feature macro: BTN_LONG_PRESS_EN adds long-press detection
// (evt_long=1 events); without it evt_long is tied to 0.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   bt        : raw button levels, asynchronous to clk
//   evt_valid : event offered to the consumer
//   evt_ready : consumer accepts the offered event
//   evt_id    : index of the button that produced the offered event
//   evt_long  : offered event is a long press
//   ovf       : sticky, a press was lost because one was already pending
//   ovf_clr   : synchronous clear of ovf (a simultaneous new overflow wins)
module btn_event_arbiter
    import btn_event_arbiter_pkg::*;
#(
    parameter int N_BTN    = 5,
    parameter int LOCKOUT  = LOCKOUT_DEF,
    parameter int LONG_CYC = LONG_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BTN-1:0]    bt,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [EVT_ID_W-1:0] evt_id,
    output logic                evt_long,
    output logic                ovf,
    input  logic                ovf_clr
);

    if (N_BTN < 2 || N_BTN > 8 || LOCKOUT < 1 || LONG_CYC < 1) begin : g_bad_cfg
        $error("btn_event_arbiter: parameter out of range");
    end

    arb_state_e          state_q;
    logic [EVT_ID_W-1:0] last_q;
    logic [N_BTN-1:0]    pend_q, pend_d;
    logic [N_BTN-1:0]    press;
    logic [N_BTN-1:0]    cand;
    logic [N_BTN-1:0]    sel_mask;
    logic [N_BTN-1:0]    gnt_short;
    logic [EVT_ID_W-1:0] gnt_id;
    logic                gnt_any;
    logic                take;
    logic                ovf_set;
`ifdef BTN_LONG_PRESS_EN
    logic [N_BTN-1:0]    long_hit;
    logic [N_BTN-1:0]    lpend_q, lpend_d;
    logic [N_BTN-1:0]    gnt_long;
`endif

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .LOCKOUT (LOCKOUT)
`ifdef BTN_LONG_PRESS_EN
            , .LONG_CYC(LONG_CYC)
`endif
        ) u_ch (
            .clk_i   (clk),
            .rst_i   (rst),
            .bt_i    (bt[i]),
            .press_o (press[i])
`ifdef BTN_LONG_PRESS_EN
            , .long_o(long_hit[i])
`endif
        );
    end

    // Round-robin pick starting just after the last granted index. A short
    // and a long event pending on the same index grant the short one first.
    always_comb begin
        int idx;
        idx      = 0;
        cand     = pend_q;
`ifdef BTN_LONG_PRESS_EN
        cand     = pend_q | lpend_q;
`endif
        gnt_any  = 1'b0;
        gnt_id   = '0;
        sel_mask = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = (int'(last_q) + k) % N_BTN;
            if (!gnt_any && cand[idx]) begin
                gnt_any       = 1'b1;
                gnt_id        = EVT_ID_W'(idx);
                sel_mask[idx] = 1'b1;
            end
        end
        take      = (state_q == ST_IDLE) && gnt_any;
        gnt_short = take ? (sel_mask & pend_q) : '0;
        // A grant clears its pending bit before the same-edge press is
        // merged, so a press during a button's own offer is not an overflow.
        pend_d    = (pend_q & ~gnt_short) | press;
        ovf_set   = |(press & pend_q & ~gnt_short);
`ifdef BTN_LONG_PRESS_EN
        gnt_long  = take ? (sel_mask & ~pend_q) : '0;
        lpend_d   = (lpend_q & ~gnt_long) | long_hit;
        ovf_set   = ovf_set | (|(long_hit & lpend_q & ~gnt_long));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= EVT_ID_W'(N_BTN - 1);
            pend_q    <= '0;
            ovf       <= 1'b0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
`ifdef BTN_LONG_PRESS_EN
            lpend_q   <= '0;
            evt_long  <= 1'b0;
`endif
        end else begin
            pend_q <= pend_d;
`ifdef BTN_LONG_PRESS_EN
            lpend_q <= lpend_d;
`endif
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        evt_id    <= gnt_id;
                        evt_valid <= 1'b1;
                        state_q   <= ST_OFFER;
`ifdef BTN_LONG_PRESS_EN
                        evt_long  <= |gnt_long;
`endif
                    end
                end
                ST_OFFER: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        last_q    <= evt_id;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifndef BTN_LONG_PRESS_EN
    assign evt_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Self-checking bench for btn_event_arbiter. A behavioural model works from
// the sampled button history (press timestamps, run lengths) and a pending
// set, and predicts the handshake outputs every cycle.
module tb_btn_event_arbiter;

    localparam int N    = 5;
    localparam int LOCK = 2000;
    localparam int LCYC = 100;
`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] bt;
    logic         evt_valid;
    logic         evt_ready;
    logic [2:0]   evt_id;
    logic         evt_long;
    logic         ovf;
    logic         ovf_clr;

    always #5 clk = ~clk;

    btn_event_arbiter #(
        .N_BTN    (N),
        .LOCKOUT  (LOCK),
        .LONG_CYC (LCYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bt        (bt),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_long  (evt_long),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] hist[$];      // bt as sampled on each edge since reset
    logic [N-1:0] m_pend, m_lpend;
    int           lastacc[N];   // sample index of last accepted press, -1 none
    int           runlen[N];    // consecutive synchronized-high samples
    bit           m_offer, m_long, m_ovf;
    int           m_id, m_last;
    logic [3:0]   obs[$];       // observed handshakes {long, id}

    function automatic bit hb(int idx, int i);
        if (idx < 0 || idx >= hist.size()) return 1'b0;
        return hist[idx][i];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_pend  = '0;
        m_lpend = '0;
        for (int i = 0; i < N; i++) begin
            lastacc[i] = -1;
            runlen[i]  = 0;
        end
        m_offer = 0;
        m_long  = 0;
        m_ovf   = 0;
        m_id    = 0;
        m_last  = N - 1;
    endtask

    task automatic model_edge();
        int e, pick;
        logic [N-1:0] acc, lhit;
        bit oset;
        hist.push_back(bt);
        e = hist.size() - 1;
        acc  = '0;
        lhit = '0;
        // A level change is seen by the edge detector two samples later.
        for (int i = 0; i < N; i++) begin
            if (hb(e - 2, i) && !hb(e - 3, i) && (lastacc[i] < 0 || e - lastacc[i] > LOCK)) begin
                acc[i]     = 1'b1;
                lastacc[i] = e;
            end
            if (hb(e - 2, i)) runlen[i]++;
            else runlen[i] = 0;
            if (LONG_EN && runlen[i] == LCYC) lhit[i] = 1'b1;
        end
        if (!m_offer) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (pick < 0 && (m_pend[idx] || m_lpend[idx])) pick = idx;
            end
            if (pick >= 0) begin
                m_offer = 1;
                m_id    = pick;
                if (m_pend[pick]) begin
                    m_long       = 0;
                    m_pend[pick] = 1'b0;
                end else begin
                    m_long        = 1;
                    m_lpend[pick] = 1'b0;
                end
            end
        end else if (evt_ready) begin
            m_offer = 0;
            m_last  = m_id;
        end
        oset = 0;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (m_pend[i]) oset = 1;
                m_pend[i] = 1'b1;
            end
            if (lhit[i]) begin
                if (m_lpend[i]) oset = 1;
                m_lpend[i] = 1'b1;
            end
        end
        if (oset) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        if (evt_valid === 1'b1 && evt_ready === 1'b1) obs.push_back({evt_long, evt_id});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("valid", evt_valid, m_offer);
        if (m_offer) begin
            chk("id", evt_id, m_id);
            chk("long", evt_long, m_long);
        end
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", evt_valid, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_long", evt_long, 0);
        chk("rst_ovf", ovf, 0);
    endtask

    initial begin
        rst       = 1'b0;
        bt        = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        @(negedge clk);
        pulse_reset();

        // Single press latency: valid on edge 4, gone on edge 5.
        evt_ready = 1'b1;
        bt[2] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c < 4) chk("lat_pre", evt_valid, 0);
            if (c == 4) begin
                chk("lat_valid", evt_valid, 1);
                chk("lat_id", evt_id, 2);
            end
            if (c == 5) chk("lat_drop", evt_valid, 0);
        end
        bt[2] = 1'b0;
        run(2010);

        // Bouncing contacts give one event; a press after lockout gives another.
        obs.delete();
        for (int b = 0; b < 5; b++) begin
            bt[2] = 1'b1;
            run($urandom_range(1, 8));
            bt[2] = 1'b0;
            run($urandom_range(1, 8));
        end
        run(30);
        chk("bounce_events", obs.size(), 1);
        run(2005);
        bt[2] = 1'b1;
        run(10);
        bt[2] = 1'b0;
        run(5);
        chk("relock_events", obs.size(), 2);

        // Three simultaneous presses with a stalled consumer.
        pulse_reset();
        obs.delete();
        evt_ready = 1'b0;
        bt = 5'b01011;
        run(4);
        chk("stall_first", evt_valid, 1);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("stall_hold_id", evt_id, 0);
        end
        evt_ready = 1'b1;
        bt = '0;
        run(12);
        chk("rr_count", obs.size(), 3);
        chk("rr_0", obs[0], 0);
        chk("rr_1", obs[1], 1);
        chk("rr_2", obs[2], 3);

        // Overflow: two further presses while the first grant is stalled.
        pulse_reset();
        evt_ready = 1'b0;
        bt[1] = 1'b1;
        run(3);
        bt[1] = 1'b0;
        run(3);
        chk("ovf_first_valid", evt_valid, 1);
        chk("ovf_first_id", evt_id, 1);
        run(2000);
        bt[1] = 1'b1;
        run(3);
        bt[1] = 1'b0;
        run(2005);
        chk("ovf_not_yet", ovf, 0);
        bt[1] = 1'b1;
        run(3);
        bt[1] = 1'b0;
        run(7);
        chk("ovf_set", ovf, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);
        evt_ready = 1'b1;
        run(10);

        // Reset during an offer discards the event.
        pulse_reset();
        evt_ready = 1'b0;
        bt[3] = 1'b1;
        run(3);
        bt[3] = 1'b0;
        run(3);
        chk("mid_offer_valid", evt_valid, 1);
        pulse_reset();
        obs.delete();
        for (int c = 0; c < 20; c++) begin
            step();
            chk("post_rst_quiet", evt_valid, 0);
        end
        evt_ready = 1'b1;
        bt[3] = 1'b1;
        run(3);
        bt[3] = 1'b0;
        run(6);
        chk("post_rst_new_press", obs.size(), 1);

`ifdef BTN_LONG_PRESS_EN
        // Long hold: short event, then one long event, then nothing.
        pulse_reset();
        obs.delete();
        evt_ready = 1'b1;
        bt[4] = 1'b1;
        run(150);
        bt[4] = 1'b0;
        run(10);
        chk("long_count", obs.size(), 2);
        chk("long_short_first", obs[0], 4'h4);
        chk("long_second", obs[1], 4'hC);
`endif

        // Randomized traffic against the model.
        pulse_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 39) == 0) bt[i] = ~bt[i];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            step();
        end
        ovf_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
